// File: rtl/iir_lp_pkg.sv
// Shared types and width helpers for the multi-channel IIR low-pass filter.
package iir_lp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STAGE,
    OUT
  } state_t;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a filter state word: sample bits plus fractional guard bits.
  function automatic int state_w(input int data_w, input int frac_w);
    return data_w + frac_w;
  endfunction

endpackage

// File: rtl/iir_lp_stage_alu.sv
// Combinational one-pole update y_new = y + floor((x - y) * alpha / 2^COEF_W).
module iir_lp_stage_alu #(
  parameter int W      = 20,
  parameter int COEF_W = 16
) (
  input  logic signed [W-1:0]      y,
  input  logic signed [W-1:0]      x,
  input  logic        [COEF_W-1:0] alpha,
  output logic signed [W-1:0]      y_new
);

  logic signed [W:0]        diff;
  logic signed [W+COEF_W:0] prod;
  logic signed [W:0]        step;
  logic signed [W:0]        sum;
  logic                     unused_lsbs;

  assign diff = {x[W-1], x} - {y[W-1], y};
  assign prod = diff * $signed({1'b0, alpha});
  // Dropping the low COEF_W bits of a signed product is an arithmetic (floor) shift.
  assign step = prod[W+COEF_W:COEF_W];
  assign sum  = {y[W-1], y} + step;
  // The result lies between x and y, so it always fits back into W bits.
  assign y_new = sum[W-1:0];
  assign unused_lsbs = ^prod[COEF_W-1:0];

endmodule

// File: rtl/iir_lowpass_mc.sv
// Time-multiplexed multi-channel cascade of one-pole low-pass sections with
// valid/ready handshakes; one stage is evaluated per clock by a shared ALU.
module iir_lowpass_mc
  import iir_lp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int FRAC_W     = 4,
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 2,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH_W-1:0]                in_ch,
  input  logic signed [DATA_W-1:0]       in_data,
  input  logic [NUM_STAGES*COEF_W-1:0]   alpha,
  input  logic                           bypass,
  input  logic                           clr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_W-1:0]                out_ch,
  output logic signed [DATA_W-1:0]       out_data,
  output logic                           err_ch
);

  localparam int W   = state_w(DATA_W, FRAC_W);
  localparam int S_W = ch_w(NUM_STAGES);

  state_t                        state_reg, state_next;
  logic [CH_W-1:0]               ch_reg;
  logic signed [W-1:0]           x_reg;
  logic [NUM_STAGES*COEF_W-1:0]  alpha_reg;
  logic                          bypass_reg;
  logic [S_W-1:0]                s_reg;
  logic                          out_valid_reg;
  logic signed [DATA_W-1:0]      out_data_reg;
  logic [CH_W-1:0]               out_ch_reg;
  logic                          err_ch_reg;

  logic signed [W-1:0]           y_mem [NUM_CH][NUM_STAGES];
  logic [NUM_CH*NUM_STAGES-1:0]  y_we;
  logic signed [W-1:0]           y_cur;
  logic signed [W-1:0]           y_new;
  logic [COEF_W-1:0]             alpha_cur;
  logic                          accept;
  logic                          ch_ok;
  logic                          clr_all;
  logic                          last_stage;

  assign in_ready   = (state_reg == IDLE) && !clr && !rst;
  assign accept     = in_valid && in_ready;
  assign ch_ok      = (int'(in_ch) < NUM_CH);
  assign clr_all    = (state_reg == IDLE) && clr;
  assign last_stage = (s_reg == S_W'(NUM_STAGES - 1));
  assign y_cur      = y_mem[ch_reg][s_reg];
  assign alpha_cur  = alpha_reg[s_reg*COEF_W +: COEF_W];

  iir_lp_stage_alu #(
    .W      (W),
    .COEF_W (COEF_W)
  ) u_alu (
    .y     (y_cur),
    .x     (x_reg),
    .alpha (alpha_cur),
    .y_new (y_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && ch_ok) state_next = STAGE;
      STAGE:   if (last_stage)      state_next = OUT;
      OUT:     if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Per-state write enables; bypassed samples never touch the stored states.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      for (genvar gj = 0; gj < NUM_STAGES; gj++) begin : g_st
        assign y_we[gi*NUM_STAGES+gj] = (state_reg == STAGE) && !bypass_reg &&
                                        (int'(ch_reg) == gi) && (int'(s_reg) == gj);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_STAGES; s++)
          y_mem[c][s] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < NUM_STAGES; s++)
          if (clr_all)                     y_mem[c][s] <= '0;
          else if (y_we[c*NUM_STAGES+s])   y_mem[c][s] <= y_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_reg        <= '0;
      x_reg         <= '0;
      alpha_reg     <= '0;
      bypass_reg    <= 1'b0;
      s_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      err_ch_reg    <= 1'b0;
    end else begin
      err_ch_reg <= accept && !ch_ok;
      case (state_reg)
        IDLE: begin
          if (accept && ch_ok) begin
            ch_reg     <= in_ch;
            x_reg      <= W'(in_data) <<< FRAC_W;
            alpha_reg  <= alpha;
            bypass_reg <= bypass;
            s_reg      <= '0;
          end
        end
        STAGE: begin
          if (!bypass_reg) x_reg <= y_new;
          s_reg <= s_reg + 1'b1;
          if (last_stage) begin
            out_valid_reg <= 1'b1;
            out_ch_reg    <= ch_reg;
            out_data_reg  <= bypass_reg ? x_reg[W-1:FRAC_W] : y_new[W-1:FRAC_W];
          end
        end
        OUT: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign err_ch    = err_ch_reg;

endmodule

// File: tb/tb_iir_lowpass_mc.sv
// Directed bench for iir_lowpass_mc with a behavioural cascade model and a
// per-cycle output checker; three channels so an out-of-range index fits in in_ch.
module tb_iir_lowpass_mc;

  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int FRAC_W     = 4;
  localparam int NUM_CH     = 3;
  localparam int NUM_STAGES = 2;
  localparam int CH_W       = 2;
  localparam logic [31:0] A_HALF = 32'h8000_8000;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [CH_W-1:0]              in_ch = '0;
  logic signed [DATA_W-1:0]     in_data = '0;
  logic [NUM_STAGES*COEF_W-1:0] alpha = '0;
  logic                         bypass = 1'b0;
  logic                         clr = 1'b0;
  logic                         out_valid;
  logic                         out_ready = 1'b1;
  logic [CH_W-1:0]              out_ch;
  logic signed [DATA_W-1:0]     out_data;
  logic                         err_ch;

  iir_lowpass_mc #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W),
    .NUM_CH(NUM_CH), .NUM_STAGES(NUM_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .alpha(alpha), .bypass(bypass),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int ch;
    int acc_cyc;
  } exp_t;

  exp_t   exp_q[$];
  bit     front_seen = 1'b0;
  longint ym [NUM_CH][NUM_STAGES];
  int     checks = 0;
  int     errors = 0;
  int     n_out = 0;
  int     last_data = 0;
  int     last_ch = 0;
  bit     err_window = 1'b0;

  function automatic longint floor_div(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic model_zero();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < NUM_STAGES; s++)
        ym[c][s] = 0;
  endtask

  // Cascade of y += alpha*(x-y) sections, evaluated with exact floor division.
  task automatic model_apply(input int ch, input int data, input logic [31:0] al, input bit byp);
    longint x, y, yn, a;
    exp_t e;
    x = longint'(data) * (64'sd1 <<< FRAC_W);
    for (int s = 0; s < NUM_STAGES; s++) begin
      a  = longint'(al[s*COEF_W +: COEF_W]);
      y  = ym[ch][s];
      yn = y + floor_div((x - y) * a, 64'sd1 <<< COEF_W);
      if (!byp) begin
        ym[ch][s] = yn;
        x = yn;
      end
    end
    e.data    = int'(floor_div(x, 64'sd1 <<< FRAC_W));
    e.ch      = ch;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic accept_sample(input int ch, input int data, input logic [31:0] al, input bit byp);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = DATA_W'(data);
    alpha    = al;
    bypass   = byp;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ch < NUM_CH) model_apply(ch, data, al, byp);
    end
  endtask

  task automatic wait_out();
    int n0, t;
    n0 = n_out;
    t = 0;
    while (n_out == n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (n_out == n0) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: handshakes %0d, required %0d", n_out, n0 + 1);
    end
  endtask

  task automatic send(input int ch, input int data, input logic [31:0] al, input bit byp);
    accept_sample(ch, data, al, byp);
    wait_out();
  endtask

  // Pulse clr in IDLE together with a competing sample: clr must win.
  task automatic do_clr();
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_ch    = '0;
    in_data  = 16'sd777;
    #1;
    check("clr_blocks_ready", int'(in_ready), 0);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    model_zero();
  endtask

  initial begin
    int d0, c0, n0;
    model_zero();

    fork
      forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
          if (!err_window) check("err_idle", int'(err_ch), 0);
          if (out_valid) begin
            check("in_ready_busy", int'(in_ready), 0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: out_data %0d out_ch %0d, no output required", out_data, out_ch);
            end else begin
              if (!front_seen) begin
                front_seen = 1'b1;
                check("latency", cyc - exp_q[0].acc_cyc, NUM_STAGES);
              end
              check("out_data", int'(out_data), exp_q[0].data);
              check("out_ch", int'(out_ch), exp_q[0].ch);
              if (out_ready) begin
                last_data = int'(out_data);
                last_ch   = int'(out_ch);
                n_out++;
                front_seen = 1'b0;
                void'(exp_q.pop_front());
              end
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_err_ch", int'(err_ch), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Step response on channel 0
    send(0, 1000, A_HALF, 1'b0);
    check("step_1", last_data, 250);
    send(0, 1000, A_HALF, 1'b0);
    check("step_2", last_data, 500);

    // Channel isolation
    do_clr();
    send(0, 1000, A_HALF, 1'b0);
    check("iso_a", last_data, 250);
    check("iso_a_ch", last_ch, 0);
    send(1, -1000, A_HALF, 1'b0);
    check("iso_b", last_data, -250);
    check("iso_b_ch", last_ch, 1);
    send(0, 1000, A_HALF, 1'b0);
    check("iso_c", last_data, 500);
    check("iso_c_ch", last_ch, 0);

    // Floor rounding
    do_clr();
    send(0, 1, A_HALF, 1'b0);
    check("floor_pos1", last_data, 0);
    do_clr();
    send(0, -1, A_HALF, 1'b0);
    check("floor_neg1", last_data, -1);
    do_clr();
    send(0, -1000, A_HALF, 1'b0);
    check("floor_neg1000", last_data, -250);

    // Frozen stages and bypass on channel 2
    do_clr();
    send(2, 1000, A_HALF, 1'b0);
    check("pre_freeze", last_data, 250);
    send(2, -5000, 32'h0, 1'b0);
    check("alpha_zero", last_data, 250);
    send(2, 1234, A_HALF, 1'b1);
    check("bypass_out", last_data, 1234);
    send(2, 1000, A_HALF, 1'b0);
    check("after_bypass", last_data, 500);

    // Near pass-through and full-scale samples
    send(1, 20000, 32'hFFFF_FFFF, 1'b0);
    send(1, 32767, 32'hFFFF_1234, 1'b0);
    send(1, -32768, 32'h4000_FFFF, 1'b0);
    send(2, -32768, 32'hFFFF_FFFF, 1'b0);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    accept_sample(1, 3000, 32'h2000_6000, 1'b0);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    #2;
    check("bp_valid", int'(out_valid), 1);
    d0 = int'(out_data);
    c0 = int'(out_ch);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_data", int'(out_data), d0);
      check("bp_hold_ch", int'(out_ch), c0);
      check("bp_in_ready", int'(in_ready), 0);
    end
    n0 = n_out;
    @(negedge clk);
    out_ready = 1'b1;
    wait_out();
    repeat (3) @(negedge clk);
    check("bp_single_hs", n_out - n0, 1);

    // Out-of-range channel
    err_window = 1'b1;
    n0 = n_out;
    accept_sample(3, 4321, A_HALF, 1'b0);
    check("err_pulse", int'(err_ch), 1);
    @(posedge clk);
    #1;
    check("err_one_cycle", int'(err_ch), 0);
    err_window = 1'b0;
    check("err_stay_idle", int'(in_ready), 1);
    repeat (6) @(negedge clk);
    check("err_no_output", n_out - n0, 0);

    // clr while busy: sample uses old states, states cleared afterwards
    accept_sample(0, 2000, A_HALF, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    wait_out();
    @(negedge clk);
    check("clr_busy_idle_ready", int'(in_ready), 0);
    @(negedge clk);
    clr = 1'b0;
    model_zero();
    send(0, 1000, A_HALF, 1'b0);
    check("clr_busy_after", last_data, 250);

    // Reset in the middle of a sample
    send(0, 1000, A_HALF, 1'b0);
    accept_sample(0, 1000, A_HALF, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 0);
    exp_q.delete();
    front_seen = 1'b0;
    model_zero();
    @(negedge clk);
    rst = 1'b0;
    n0 = n_out;
    repeat (6) @(negedge clk);
    check("rst_mid_no_output", n_out - n0, 0);
    send(0, 1000, A_HALF, 1'b0);
    check("rst_mid_after", last_data, 250);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
